// File: rtl/framebuffer_ctrl.sv
// -----------------------------------------------------------------------------
// framebuffer_ctrl
//
// Double-buffer controller for a WIDTH x HEIGHT, PIX_W-bit-per-pixel
// framebuffer held in two external single-port RAM banks (1-cycle read
// latency). The front bank (index front_sel) serves display reads; the back
// bank is first cleared to zero, then accepts pixel writes from the drawing
// engine. Once the drawer signals frame_done, the banks swap on the next
// new_frame pulse and the new back bank is cleared again.
//
// Ports
//   Clk, Reset            : system clock, asynchronous active-high reset
//   new_frame             : one-cycle vsync-aligned pulse from the output module
//   disp_x, disp_y        : display read coordinates
//   disp_pixel            : front-bank pixel for coordinates of the previous cycle
//   draw_req              : drawer write request
//   draw_x, draw_y        : drawer write coordinates
//   draw_color            : drawer write value
//   draw_ack              : combinational accept of draw_req
//   frame_done            : drawer has finished the back frame
//   back_ready            : registered, high while the back bank accepts drawing
//   front_sel             : registered index of the current front bank
//   bankN_addr/we/wdata   : RAM bank N port outputs
//   bankN_rdata           : RAM bank N read data (1-cycle latency)
// -----------------------------------------------------------------------------
module framebuffer_ctrl #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int PIX_W  = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             new_frame,
    input  logic [8:0]       disp_x,
    input  logic [7:0]       disp_y,
    output logic [PIX_W-1:0] disp_pixel,
    input  logic             draw_req,
    input  logic [8:0]       draw_x,
    input  logic [7:0]       draw_y,
    input  logic [PIX_W-1:0] draw_color,
    output logic             draw_ack,
    input  logic             frame_done,
    output logic             back_ready,
    output logic             front_sel,
    output logic [16:0]      bank0_addr,
    output logic             bank0_we,
    output logic [PIX_W-1:0] bank0_wdata,
    input  logic [PIX_W-1:0] bank0_rdata,
    output logic [16:0]      bank1_addr,
    output logic             bank1_we,
    output logic [PIX_W-1:0] bank1_wdata,
    input  logic [PIX_W-1:0] bank1_rdata
);

    localparam int ADDR_W = 17;
    localparam logic [ADDR_W-1:0] NPIX = ADDR_W'(WIDTH * HEIGHT);

    localparam logic [1:0] S_CLEAR     = 2'd0;
    localparam logic [1:0] S_DRAW      = 2'd1;
    localparam logic [1:0] S_WAIT_SWAP = 2'd2;

    // Linear pixel address y*WIDTH + x; the default width uses shift-adds.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x,
                                                   input logic [7:0] y);
        logic [ADDR_W-1:0] yy;
        logic [ADDR_W-1:0] xx;
        yy = {9'd0, y};
        xx = {8'd0, x};
        if (WIDTH == 320) begin
            pix_addr = (yy << 8) + (yy << 6) + xx;
        end else begin
            pix_addr = ADDR_W'(int'(y) * WIDTH) + xx;
        end
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              front_sel_q, front_sel_d;
    logic              front_sel_dly_q, front_sel_dly_d;
    logic              disp_valid_q, disp_valid_d;
    logic              back_ready_q, back_ready_d;
    logic              wr_we_q, wr_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;

    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] draw_addr;
    logic              draw_in_range;

    assign disp_addr     = pix_addr(disp_x, disp_y);
    assign draw_addr     = pix_addr(draw_x, draw_y);
    assign draw_in_range = (32'(draw_x) < WIDTH) && (32'(draw_y) < HEIGHT);

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        front_sel_d  = front_sel_q;
        disp_valid_d = disp_valid_q;
        wr_we_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        draw_ack     = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // One clear write per cycle. The counter stops one past the
                // last address so the final clear write is on the RAM port
                // before DRAW (and draw_ack) can begin.
                if (clr_cnt_q == NPIX) begin
                    state_d = S_DRAW;
                end else begin
                    wr_we_d   = 1'b1;
                    wr_addr_d = clr_cnt_q;
                    wr_data_d = '0;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            S_DRAW: begin
                draw_ack = draw_req;
                // Out-of-range requests are acknowledged but never written.
                if (draw_req && draw_in_range) begin
                    wr_we_d   = 1'b1;
                    wr_addr_d = draw_addr;
                    wr_data_d = draw_color;
                end
                // new_frame is deliberately not looked at here: a swap
                // needs a fresh pulse after the frame is complete.
                if (frame_done) begin
                    state_d = S_WAIT_SWAP;
                end
            end
            S_WAIT_SWAP: begin
                if (new_frame) begin
                    front_sel_d  = ~front_sel_q;
                    disp_valid_d = 1'b1;
                    clr_cnt_d    = '0;
                    state_d      = S_CLEAR;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        back_ready_d    = (state_d == S_DRAW);
        // Delayed bank select follows the RAM read latency, so a read issued
        // in the swap cycle is still taken from the old front bank.
        front_sel_dly_d = front_sel_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= S_CLEAR;
            clr_cnt_q       <= '0;
            front_sel_q     <= 1'b0;
            front_sel_dly_q <= 1'b0;
            disp_valid_q    <= 1'b0;
            back_ready_q    <= 1'b0;
            wr_we_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            front_sel_q     <= front_sel_d;
            front_sel_dly_q <= front_sel_dly_d;
            disp_valid_q    <= disp_valid_d;
            back_ready_q    <= back_ready_d;
            wr_we_q         <= wr_we_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
        end
    end

    assign front_sel  = front_sel_q;
    assign back_ready = back_ready_q;

    // Front bank gets the display address and never writes; back bank is
    // driven from the write pipeline register.
    always_comb begin
        bank0_wdata = wr_data_q;
        bank1_wdata = wr_data_q;
        if (front_sel_q) begin
            bank0_addr = wr_addr_q;
            bank0_we   = wr_we_q;
            bank1_addr = disp_addr;
            bank1_we   = 1'b0;
        end else begin
            bank0_addr = disp_addr;
            bank0_we   = 1'b0;
            bank1_addr = wr_addr_q;
            bank1_we   = wr_we_q;
        end
    end

    always_comb begin
        disp_pixel = '0;
        if (disp_valid_q) begin
            disp_pixel = front_sel_dly_q ? bank1_rdata : bank0_rdata;
        end
    end

endmodule

// File: doc/framebuffer_ctrl.md
# framebuffer_ctrl

Double-buffer controller for the 320x240, 3-bit-per-pixel framebuffer. It owns two single-port pixel RAM banks:
- The front bank serves display reads from the output module.
- The back bank accepts pixel writes from the drawing engine.

It clears the back bank after every swap and swaps banks only on a vsync-aligned `new_frame` pulse, after the drawer has declared its frame complete. The block sits between the drawing engine, the output module and the two RAM banks.

## Interface
Parameters:
- `WIDTH`, default 320: pixels per line.
- `HEIGHT`, default 240: lines per frame.
- `PIX_W`, default 3: palette index width.

Ports:
- `Clk` in 1: single system clock; all logic is rising-edge.
- `Reset` in 1: asynchronous, active-high.
- `new_frame` in 1: one-cycle pulse per frame from the output module.
- `disp_x` in 9: display read x coordinate.
- `disp_y` in 8: display read y coordinate.
- `disp_pixel` out PIX_W: front-bank pixel for the coordinates presented one cycle earlier.
- `draw_req` in 1: drawer requests a pixel write.
- `draw_x` in 9, `draw_y` in 8: pixel write coordinates.
- `draw_color` in PIX_W: pixel write value.
- `draw_ack` out 1: combinational; the write is accepted this cycle.
- `frame_done` in 1: pulse; the drawer has finished the back frame.
- `back_ready` out 1: registered; high while the block is in DRAW.
- `front_sel` out 1: registered; index of the current front bank.
- `bank0_addr` out 17, `bank0_we` out 1, `bank0_wdata` out PIX_W, `bank0_rdata` in PIX_W: bank 0 RAM port; the RAM has 1-cycle read latency.
- `bank1_addr`, `bank1_we`, `bank1_wdata`, `bank1_rdata`: same as bank 0, for bank 1.

## Operation
- Address computation: addr = y*WIDTH + x, computed as (y<<8)+(y<<6)+x for WIDTH=320, 17 bits wide. The maximum address is 76799.
- Front bank (index `front_sel`):
  - addr = display address, computed combinationally from `disp_x`/`disp_y`.
  - we = 0.
- Back bank:
  - addr, we and wdata come from the write pipeline register.
- State machine, with states CLEAR, DRAW and WAIT_SWAP:
  - CLEAR:
    - A 17-bit counter writes 0 to back-bank addresses 0..76799, one per cycle.
    - `draw_ack`=0.
    - After the write to 76799 is issued, go to DRAW.
  - DRAW:
    - `draw_ack` = `draw_req`.
    - Each accepted request registers one write.
    - A request with x>=WIDTH or y>=HEIGHT is acked but discarded (we=0).
    - `frame_done`=1 → WAIT_SWAP. A write accepted in that same cycle still completes.
  - WAIT_SWAP:
    - `draw_ack`=0.
    - On `new_frame`: toggle `front_sel`, set `disp_valid`, reset the clear counter to 0, go to CLEAR.
- Ignored events:
  - `new_frame` in CLEAR or DRAW causes no swap.
  - `frame_done` outside DRAW is ignored.
  - `new_frame` and `frame_done` in the same DRAW cycle → WAIT_SWAP only; the swap waits for the next `new_frame`.
- Display mux:
  - `disp_pixel` = rdata of the bank selected by `front_sel_d`, where `front_sel_d` is `front_sel` delayed by 1 cycle. This keeps the pipeline aligned across a swap.
  - `disp_pixel` is forced to 0 while `disp_valid`=0, i.e. before the first swap after reset.

## Timing
- Reset values:
  - state = CLEAR, clear counter = 0.
  - `front_sel`=0, `front_sel_d`=0, `disp_valid`=0.
  - `back_ready`=0, `draw_ack`=0.
  - Write pipeline register: we=0, addr=0, wdata=0.
  - `disp_pixel`=0.
- Reset mid-operation: same state as above, immediately. Any in-flight write is dropped.
- Display read latency:
  - Coordinates at cycle N → `disp_pixel` at cycle N+1. There is no extra register stage; the RAM's internal register provides the delay.
  - This satisfies the output module's 1-cycle expectation.
- Write latency:
  - Acceptance at cycle N → back-bank we=1 during cycle N+1.
  - Throughput is one write per cycle.
- Clear duration: 76800 write cycles. `back_ready` rises on the first DRAW cycle.
- Swap boundary:
  - `front_sel` changes the cycle after the `new_frame` pulse.
  - The first CLEAR write reaches the new back bank (the old front bank) in the cycle after that.
  - The display read issued in the `new_frame` cycle still returns data from the old front bank.

## Test plan
- **Reset then clear:**
  - Stimulus: assert `Reset`, release it, hold `draw_req`=1.
  - Required response: bank1 we=1 for exactly 76800 cycles with wdata=0 at addrs 0..76799; `draw_ack`=0 throughout; `back_ready`=1 on the following cycle.
- **Draw write:**
  - Stimulus: in DRAW, `draw_req`=1, (x,y)=(5,2), color=6.
  - Required response: `draw_ack`=1 that cycle; next cycle bank1 addr=645, we=1, wdata=6.
- **Out-of-range write:**
  - Stimulus: (x,y)=(320,0) or (0,240).
  - Required response: `draw_ack`=1; no bank we asserted.
- **Swap:**
  - Stimulus: `frame_done`, then `new_frame` 10 cycles later.
  - Required response: `front_sel` 0→1; `disp_valid`=1; clear begins on bank0; display reads now address bank1, and `disp_pixel` at (5,2) = 6.
- **Simultaneous events:**
  - Stimulus: `frame_done` and `new_frame` in the same DRAW cycle.
  - Required response: no swap; `front_sel` unchanged until the next `new_frame`.
- **Pre-swap display:**
  - Stimulus: before the first swap, bank0_rdata=5.
  - Required response: `disp_pixel`=0.
